// File: rtl/fetch_pc_if.sv
// Fetch-unit control/status bundle: pipeline redirect controls in, fetch address and CP0 flags out.
// master = fetch_pc_unit, slave = pipeline/hazard/CP0 side.
interface fetch_pc_if #(
  parameter int unsigned CNT_W = 32
);
  logic             stall;
  logic             br_valid;
  logic [31:0]      br_target;
  logic             d_is_bj;
  logic             exc_req;
  logic             eret_req;
  logic [31:0]      epc;
  logic [31:0]      fetch_addr;
  logic [31:0]      pc_plus8;
  logic             f_bd;
  logic             f_adel;
  logic [4:0]       f_exc_code;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  stall, br_valid, br_target, d_is_bj, exc_req, eret_req, epc,
    output fetch_addr, pc_plus8, f_bd, f_adel, f_exc_code, fetch_cnt, stall_cnt
  );

  modport slave (
    output stall, br_valid, br_target, d_is_bj, exc_req, eret_req, epc,
    input  fetch_addr, pc_plus8, f_bd, f_adel, f_exc_code, fetch_cnt, stall_cnt
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// F-stage PC owner: sequential fetch, delay-slot redirects, exception entry / ERET return,
// fetch address error detection and fetch/stall event counters.
module fetch_pc_unit #(
  parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
  parameter logic [31:0] TEXT_LAST = 32'h0000_4ffc,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter int unsigned CNT_W     = 32
) (
  input logic       clk,
  input logic       reset,
  fetch_pc_if.master bus
);

  logic [31:0]      pc_q, pc_d;
  logic             bd_q, bd_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             adel;

  // Exception and ERET override stall; branch only takes effect when F advances.
  always_comb begin
    pc_d        = pc_q;
    bd_d        = bd_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.exc_req) begin
      pc_d        = EXC_ENTRY;
      bd_d        = 1'b0;
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    end else if (bus.eret_req) begin
      pc_d        = bus.epc;
      bd_d        = 1'b0;
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    end else if (bus.stall) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      pc_d        = bus.br_valid ? bus.br_target : pc_q + 32'd4;
      bd_d        = bus.d_is_bj;
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= TEXT_BASE;
      bd_q        <= 1'b0;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      bd_q        <= bd_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    adel           = (pc_q < TEXT_BASE) || (pc_q > TEXT_LAST) || (pc_q[1:0] != 2'b00);
    bus.fetch_addr = pc_q;
    bus.pc_plus8   = pc_q + 32'd8;
    bus.f_bd       = bd_q;
    bus.f_adel     = adel;
    bus.f_exc_code = adel ? 5'd4 : 5'd0;
    bus.fetch_cnt  = fetch_cnt_q;
    bus.stall_cnt  = stall_cnt_q;
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed plus randomized bench for fetch_pc_unit, checked against a behavioural PC model.
module tb_fetch_pc_unit;
  localparam logic [31:0] TextBase = 32'h0000_3000;
  localparam logic [31:0] TextLast = 32'h0000_4ffc;
  localparam logic [31:0] ExcEntry = 32'h0000_4180;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_bd;
  logic [31:0] m_fcnt, m_scnt;

  fetch_pc_if #(.CNT_W(32)) bus ();

  fetch_pc_unit #(
    .TEXT_BASE(TextBase),
    .TEXT_LAST(TextLast),
    .EXC_ENTRY(ExcEntry),
    .CNT_W    (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = TextBase; m_bd = 1'b0; m_fcnt = 0; m_scnt = 0;
  endtask

  task automatic check_all(input string tag);
    logic exp_adel;
    exp_adel = (m_pc < TextBase) || (m_pc > TextLast) || (m_pc % 4 != 0);
    check({tag, ".fetch_addr"}, bus.fetch_addr, m_pc);
    check({tag, ".pc_plus8"}, bus.pc_plus8, m_pc + 32'd8);
    check({tag, ".f_bd"}, {31'd0, bus.f_bd}, {31'd0, m_bd});
    check({tag, ".f_adel"}, {31'd0, bus.f_adel}, {31'd0, exp_adel});
    check({tag, ".f_exc_code"}, {27'd0, bus.f_exc_code}, exp_adel ? 32'd4 : 32'd0);
    check({tag, ".fetch_cnt"}, bus.fetch_cnt, m_fcnt);
    check({tag, ".stall_cnt"}, bus.stall_cnt, m_scnt);
  endtask

  // Apply one cycle of inputs, advance the model by the priority rules, then compare.
  task automatic cyc(input logic s, input logic b, input logic [31:0] t, input logic bj,
                     input logic e, input logic r, input logic [31:0] ep, input string tag);
    bus.stall = s; bus.br_valid = b; bus.br_target = t; bus.d_is_bj = bj;
    bus.exc_req = e; bus.eret_req = r; bus.epc = ep;
    @(posedge clk);
    #1;
    if (e) begin
      m_pc = ExcEntry; m_bd = 1'b0; m_fcnt++;
    end else if (r) begin
      m_pc = ep; m_bd = 1'b0; m_fcnt++;
    end else if (s) begin
      m_scnt++;
    end else begin
      m_pc = b ? t : m_pc + 32'd4; m_bd = bj; m_fcnt++;
    end
    check_all(tag);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return TextBase + 32'($urandom_range(0, 2047)) * 32'd4;
  endfunction

  initial begin
    reset = 1'b1;
    bus.stall = 0; bus.br_valid = 0; bus.br_target = 0; bus.d_is_bj = 0;
    bus.exc_req = 0; bus.eret_req = 0; bus.epc = 0;
    model_reset();
    #1;
    check_all("reset");
    check("reset_addr", bus.fetch_addr, 32'h3000);
    check("reset_plus8", bus.pc_plus8, 32'h3008);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, "seq");
    check("seq_cnt", bus.fetch_cnt, 32'd4);
    check("seq_pc", bus.fetch_addr, 32'h3010);
    check("seq_plus8", bus.pc_plus8, 32'h3018);

    cyc(0, 0, 0, 1, 0, 0, 0, "bj");
    check("slot_bd", {31'd0, bus.f_bd}, 32'd1);
    check("slot_pc", bus.fetch_addr, 32'h3014);
    cyc(0, 1, 32'h3100, 0, 0, 0, 0, "br");
    check("br_pc", bus.fetch_addr, 32'h3100);

    cyc(0, 1, 32'h3020, 0, 0, 0, 0, "to3020");
    cyc(1, 0, 0, 0, 0, 0, 0, "stall0");
    cyc(1, 1, 32'h3300, 0, 0, 0, 0, "stall_br");
    cyc(1, 0, 0, 0, 0, 0, 0, "stall2");
    check("stall_pc", bus.fetch_addr, 32'h3020);
    check("stall_cnt3", bus.stall_cnt, 32'd3);
    cyc(0, 0, 0, 0, 0, 0, 0, "resume");
    check("resume_pc", bus.fetch_addr, 32'h3024);

    cyc(0, 1, 32'h3040, 1, 0, 0, 0, "to3040");
    cyc(1, 1, 32'h3100, 0, 1, 0, 0, "exc_stall");
    check("exc_pc", bus.fetch_addr, 32'h4180);
    cyc(0, 0, 0, 0, 0, 1, 32'h3044, "eret");
    check("eret_pc", bus.fetch_addr, 32'h3044);
    cyc(0, 0, 0, 0, 1, 1, 32'h3200, "exc_eret");
    check("exc_wins", bus.fetch_addr, 32'h4180);

    cyc(0, 1, 32'h5000, 0, 0, 0, 0, "bad_hi");
    check("bad_hi_code", {27'd0, bus.f_exc_code}, 32'd4);
    cyc(0, 0, 0, 0, 0, 0, 0, "bad_hi_next");
    check("bad_hi_pc", bus.fetch_addr, 32'h5004);
    cyc(0, 1, 32'h3002, 0, 0, 0, 0, "bad_align");
    cyc(0, 0, 0, 0, 0, 0, 0, "bad_align_next");
    check("bad_align_pc", bus.fetch_addr, 32'h3006);
    cyc(0, 1, 32'h4ffc, 0, 0, 0, 0, "last_ok");
    check("last_ok_adel", {31'd0, bus.f_adel}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, "past_last");
    cyc(0, 1, 32'h2ffc, 0, 0, 0, 0, "below_base");
    cyc(0, 1, 32'hffff_fffc, 0, 0, 0, 0, "top");
    cyc(0, 0, 0, 0, 0, 0, 0, "wrap");
    check("wrap_pc", bus.fetch_addr, 32'h0);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, rand_addr(),
          $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 15) == 0, rand_addr(), "rand");
    end

    // Asynchronous reset while stalled, observed before the next clock edge
    bus.stall = 1; bus.br_valid = 0; bus.exc_req = 0; bus.eret_req = 0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    check("async_reset_pc", bus.fetch_addr, 32'h3000);
    check("async_reset_fcnt", bus.fetch_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Initiator side of the instruction-memory read interface: owns the F-stage PC and drives the fetch address into instruction memory every cycle.
- Sequences sequential fetch, branch/jump redirects (MIPS delay-slot semantics), exception entry and ERET return.
- Flags fetch address errors (AdEL) and the branch-delay bit for CP0.
- Keeps fetch and stall event counters for bench/debug visibility.

Parameters:
TEXT_BASE, 32'h0000_3000, reset PC and lowest legal fetch address
TEXT_LAST, 32'h0000_4ffc, highest legal fetch address (word aligned)
EXC_ENTRY, 32'h0000_4180, exception handler entry address
CNT_W, 32, width of the event counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  freeze F stage (hazard unit)
br_valid  input  1  D-stage branch/jump taken this cycle
br_target  input  32  redirect target for br_valid
d_is_bj  input  1  instruction now in D is a branch/jump (delay-slot marker)
exc_req  input  1  CP0 takes exception/interrupt this cycle
eret_req  input  1  ERET committing this cycle
epc  input  32  return address for eret_req
fetch_addr  output  32  address presented to instruction memory (= PC)
pc_plus8  output  32  fetch_addr + 8, link value for JAL/BAL
f_bd  output  1  instruction at fetch_addr is a delay slot
f_adel  output  1  fetch_addr illegal
f_exc_code  output  5  5'd4 when f_adel, else 5'd0
fetch_cnt  output  CNT_W  cycles in which a new PC was accepted
stall_cnt  output  CNT_W  cycles with stall=1 and no override

Behaviour:
- Reset (async, immediate):
  - PC=TEXT_BASE, f_bd=0, both counters=0.
  - Outputs follow combinationally: fetch_addr=32'h3000, pc_plus8=32'h3008, f_adel=0, f_exc_code=0.
- PC update on rising clk. Priority, highest first:
  1. exc_req: PC<=EXC_ENTRY, f_bd<=0. Overrides stall.
  2. eret_req: PC<=epc, f_bd<=0. Overrides stall.
  3. stall: PC and f_bd hold; stall_cnt+=1.
  4. br_valid: PC<=br_target.
  5. Otherwise: PC<=PC+4, 32-bit wrap, no saturation.
- For cases 4 and 5: f_bd<=d_is_bj. The instruction being fetched next follows a branch only if D currently holds one. br_valid itself does not set f_bd.
- fetch_cnt+=1 on every non-stall cycle, including exception and ERET cycles. Both counters wrap modulo 2^CNT_W.
- exc_req and eret_req asserted together: exc_req wins; eret is dropped.
- br_valid while stall=1: ignored. The hazard unit re-presents it once D advances.
- f_adel is combinational from the PC. It is 1 when any of the following holds:
  - PC < TEXT_BASE
  - PC > TEXT_LAST
  - PC[1:0] != 0
- f_adel does not alter sequencing; the pipeline converts the fetched word to a NOP and CP0 raises the exception via exc_req.
- pc_plus8 is combinational. It is valid even when f_adel=1.
- Latency:
  - Redirect: the target appears on fetch_addr one cycle after the request edge.
  - Memory read: zero cycles (combinational).
- Reset mid-operation: all state returns to reset values at once, regardless of stall or pending requests. Deassertion is sampled like any input.

Test Plan:
- Reset, then 4 free-running cycles -> fetch_addr 3000,3004,3008,300c; fetch_cnt=4; f_bd=0; f_adel=0.
- At PC=3010, d_is_bj=1 for one cycle, next cycle br_valid=1 br_target=3100 -> fetch_addr 3014 with f_bd=1, then 3100 with f_bd=0; pc_plus8 at 3010 = 3018.
- stall=1 for 3 cycles at 3020, br_valid pulsed during stall -> fetch_addr stays 3020, branch ignored, stall_cnt=3, fetch_cnt unchanged; resumes at 3024.
- stall=1 with exc_req=1 at PC=3040 -> next fetch_addr 4180, f_bd=0, fetch_cnt increments; then eret_req=1 epc=3044 -> fetch_addr 3044.
- Simultaneous exc_req and eret_req (epc=3200) -> fetch_addr 4180.
- br_target=5000, then separately br_target=3002 -> each gives f_adel=1, f_exc_code=4; PC still advances to 5004 / 3006. Assert reset while stall=1 -> fetch_addr 3000 immediately, before the next clk edge, with counters cleared.
